ped_pass_request: RTL

- Upstream conditioner for the traffic-light controller's `pass` input.
- Takes a raw, asynchronous pedestrian push-button and turns it into a clean single-cycle `pass` pulse on sysclk: 2-flop sync, then debounce, then rising-edge detect.
- Enforces a minimum spacing between successive pulses (cooldown) and holds at most one press pending while the cooldown runs.
- Exposes status and a dropped-press counter for debug.

---
 rtl/ped_pass_request.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ped_pass_request.sv
// Pedestrian push-button conditioner: sync, debounce, edge detect and
// cooldown-spaced single-cycle pass pulses with one-deep press latching.
module ped_pass_request #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int COOLDOWN_CYCLES = 1024,
   parameter int CNT_W           = 16
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       enable,
   output logic       pass,
   output logic       btn_clean,
   output logic       pending,
   output logic       cooldown_busy,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      COOLDOWN
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 2);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_db_cnt;
   logic [CNT_W-1:0]       r_cd_cnt;
   logic                   r_clean;
   logic                   r_clean_d;
   logic                   r_pend;
   logic [7:0]             r_drop;
   logic                   r_pass;
   logic                   r_busy;
   state_t                 r_state;

   logic w_s;
   logic w_press;
   logic w_can;
   logic w_go;

   assign w_s     = r_sync[SYNC_STAGES-1];
   assign w_press = r_clean & ~r_clean_d;
   // Issue is only possible from IDLE or on the last cooldown cycle
   assign w_can   = (r_state == IDLE) |
                    ((r_state == COOLDOWN) & (r_cd_cnt == '0));
   assign w_go    = w_can & (w_press | r_pend) & enable;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_sync    <= '0;
         r_db_cnt  <= '0;
         r_clean   <= 1'b0;
         r_clean_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw};
         r_clean_d <= r_clean;
         if (w_s != r_clean) begin
            if (r_db_cnt == DB_LAST) begin
               r_clean  <= ~r_clean;
               r_db_cnt <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + ONE;
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cd_cnt <= '0;
         r_pass   <= 1'b0;
         r_busy   <= 1'b0;
         r_pend   <= 1'b0;
         r_drop   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_state <= ISSUE;
                  r_pass  <= 1'b1;
               end
            end
            ISSUE: begin
               r_state  <= COOLDOWN;
               r_pass   <= 1'b0;
               r_busy   <= 1'b1;
               r_cd_cnt <= CD_LOAD;
            end
            COOLDOWN: begin
               if (r_cd_cnt != '0) begin
                  r_cd_cnt <= r_cd_cnt - ONE;
               end else begin
                  r_busy <= 1'b0;
                  if (w_go) begin
                     r_state <= ISSUE;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_pass  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_go) begin
            r_pend <= 1'b0;
         end else if (w_press) begin
            if (!r_pend) begin
               r_pend <= 1'b1;
            end else if (r_drop != 8'hFF) begin
               r_drop <= r_drop + 8'd1;
            end
         end
      end
   end

   assign pass          = r_pass;
   assign btn_clean     = r_clean;
   assign pending       = r_pend;
   assign cooldown_busy = r_busy;
   assign drop_cnt      = r_drop;

endmodule
